bit_window_reader: RTL

BIT_WINDOW_READER -- requirements
Module: bit_window_reader

---
 rtl/bitrdr_pkg.sv | 34 +++
 rtl/bit_window_reader_if.sv | 41 ++++
 rtl/bitrdr_shift_merge.sv | 44 ++++
 rtl/bit_window_reader.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/bitrdr_pkg.sv
// bitrdr_pkg: shared definitions for the bit window reader.
//   - state_e: reader states (PRIME, AVAIL, TAIL, DONE)
//   - sr_width / nw_width / cnt_width: derive shift-register, flush-count
//     and valid-bit-counter widths from the window width WIN_W.
package bitrdr_pkg;

  localparam logic [1:0] ST_PRIME = 2'd0;
  localparam logic [1:0] ST_AVAIL = 2'd1;
  localparam logic [1:0] ST_TAIL  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    PRIME = ST_PRIME,
    AVAIL = ST_AVAIL,
    TAIL  = ST_TAIL,
    DONE  = ST_DONE
  } state_e;

  // Shift register holds one full window plus one pending byte.
  function automatic int sr_width(input int win_w);
    return win_w + 8;
  endfunction

  // Width of the flush-count command (0..WIN_W).
  function automatic int nw_width(input int win_w);
    return $clog2(win_w + 1);
  endfunction

  // Width of the valid-bit counter (0..SR_W).
  function automatic int cnt_width(input int win_w);
    return $clog2(win_w + 9);
  endfunction

endpackage

// File: rtl/bit_window_reader_if.sv
// bit_window_reader_if: stream/command/result bundle of the bit window reader.
//   Byte input  : in_valid, in_ready, in_data[7:0], in_last
//   Flush cmd   : flush_valid, flush_ready, flush_n[NW-1:0]
//   Align cmd   : align_valid, align_ready
//   Results     : win[WIN_W-1:0], win_valid, done, err, bits_consumed[31:0]
// master drives the commands and bytes; slave is the reader itself.
interface bit_window_reader_if #(
  parameter int WIN_W = 32
) ();
  import bitrdr_pkg::*;

  localparam int NW = nw_width(WIN_W);

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             flush_valid;
  logic             flush_ready;
  logic [NW-1:0]    flush_n;
  logic             align_valid;
  logic             align_ready;
  logic [WIN_W-1:0] win;
  logic             win_valid;
  logic             done;
  logic             err;
  logic [31:0]      bits_consumed;

  modport master (
    output in_valid, in_data, in_last, flush_valid, flush_n, align_valid,
    input  in_ready, flush_ready, align_ready, win, win_valid, done, err,
           bits_consumed
  );

  modport slave (
    input  in_valid, in_data, in_last, flush_valid, flush_n, align_valid,
    output in_ready, flush_ready, align_ready, win, win_valid, done, err,
           bits_consumed
  );

endinterface

// File: rtl/bitrdr_shift_merge.sv
// bitrdr_shift_merge: combinational datapath of the bit window reader.
//   sr_i/cnt_i        : current MSB-aligned shift register and valid-bit count
//   shift_i           : bits to discard this cycle (already clamped, <= cnt_i)
//   byte_i/byte_en_i  : byte to append behind the remaining valid bits
//   sr_next_o/cnt_next_o : resulting register contents and count
// The shift is applied first, the byte is then placed directly below the
// surviving valid bits.
module bitrdr_shift_merge
  import bitrdr_pkg::*;
#(
  parameter int WIN_W = 32
) (
  input  logic [sr_width(WIN_W)-1:0]  sr_i,
  input  logic [cnt_width(WIN_W)-1:0] cnt_i,
  input  logic [cnt_width(WIN_W)-1:0] shift_i,
  input  logic [7:0]                  byte_i,
  input  logic                        byte_en_i,
  output logic [sr_width(WIN_W)-1:0]  sr_next_o,
  output logic [cnt_width(WIN_W)-1:0] cnt_next_o
);

  localparam int SR_W = sr_width(WIN_W);
  localparam int CW   = cnt_width(WIN_W);

  logic [SR_W-1:0] sr_sh_s;
  logic [SR_W-1:0] ins_s;
  logic [CW-1:0]   cnt_sh_s;

  // Shift out consumed bits, then OR the new byte in below the remaining bits.
  always_comb begin
    sr_sh_s  = sr_i << shift_i;
    cnt_sh_s = cnt_i - shift_i;
    // Top-aligned byte moved down by cnt' equals byte << (SR_W-8-cnt').
    ins_s    = {byte_i, {(SR_W-8){1'b0}}} >> cnt_sh_s;
    if (byte_en_i) begin
      sr_next_o  = sr_sh_s | ins_s;
      cnt_next_o = cnt_sh_s + CW'(4'd8);
    end else begin
      sr_next_o  = sr_sh_s;
      cnt_next_o = cnt_sh_s;
    end
  end

endmodule

// File: rtl/bit_window_reader.sv
// bit_window_reader: presents the next WIN_W bits of a byte stream (MSB
// first) and consumes them on flush/align commands.
//   clk, rst : clock and synchronous active-high reset
//   bus      : bit_window_reader_if.slave (byte input, flush/align commands,
//              window, status and consumed-bit counter)
// Optional feature macro: BITRDR_ALIGN_EN enables the align-to-byte command;
// without it align_ready is 0 and align_valid is ignored.
// Ready signals depend on registered state only, except align_ready which
// yields to a concurrent flush request.
module bit_window_reader
  import bitrdr_pkg::*;
#(
  parameter int WIN_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  bit_window_reader_if.slave  bus
);

  localparam int SR_W = sr_width(WIN_W);
  localparam int NW   = nw_width(WIN_W);
  localparam int CW   = cnt_width(WIN_W);
  localparam logic [CW-1:0] WIN_C = CW'(WIN_W);

  logic [SR_W-1:0] sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  state_e          state_q, state_d;
  logic            err_q, err_d;
  logic [31:0]     bc_q, bc_d;

  logic            in_ready_s;
  logic            win_valid_s;
  logic            align_ready_s;
  logic            byte_acc_s;
  logic            flush_acc_s;
  logic            align_acc_s;
  logic            over_s;
  logic [CW-1:0]   fn_s;
  logic [CW-1:0]   n_win_s;
  logic [CW-1:0]   n_s;
  logic [CW-1:0]   shift_s;
  logic [SR_W-1:0] sr_m_s;
  logic [CW-1:0]   cnt_m_s;

  assign win_valid_s = (state_q == AVAIL) || (state_q == TAIL);
  assign in_ready_s  = ((state_q == PRIME) || (state_q == AVAIL)) && (cnt_q <= WIN_C);
  assign byte_acc_s  = bus.in_valid && in_ready_s;
  assign flush_acc_s = bus.flush_valid && win_valid_s;

`ifdef BITRDR_ALIGN_EN
  assign align_ready_s = win_valid_s && !bus.flush_valid;
  assign align_acc_s   = bus.align_valid && align_ready_s;
`else
  logic unused_align_s;
  assign unused_align_s = bus.align_valid;
  assign align_ready_s  = 1'b0;
  assign align_acc_s    = 1'b0;
`endif

  // Clamp the flush amount and choose this cycle's shift (flush beats align).
  always_comb begin
    fn_s = CW'(bus.flush_n);
    if (fn_s > WIN_C) begin
      over_s  = 1'b1;
      n_win_s = WIN_C;
    end else begin
      over_s  = 1'b0;
      n_win_s = fn_s;
    end
    // Only reachable in TAIL: the stream ran short, clamp without error.
    n_s = (n_win_s > cnt_q) ? cnt_q : n_win_s;
    if (flush_acc_s) begin
      shift_s = n_s;
    end else if (align_acc_s) begin
      shift_s = {{(CW-3){1'b0}}, cnt_q[2:0]};
    end else begin
      shift_s = '0;
    end
  end

  bitrdr_shift_merge #(
    .WIN_W (WIN_W)
  ) u_merge (
    .sr_i       (sr_q),
    .cnt_i      (cnt_q),
    .shift_i    (shift_s),
    .byte_i     (bus.in_data),
    .byte_en_i  (byte_acc_s),
    .sr_next_o  (sr_m_s),
    .cnt_next_o (cnt_m_s)
  );

  // Next-state: datapath result, sticky error, consumed count and FSM.
  always_comb begin
    sr_d    = sr_m_s;
    cnt_d   = cnt_m_s;
    err_d   = err_q | (flush_acc_s & over_s);
    bc_d    = bc_q + 32'(shift_s);
    state_d = state_q;
    case (state_q)
      PRIME, AVAIL: begin
        if (byte_acc_s && bus.in_last) begin
          state_d = TAIL;
        end else if (cnt_m_s >= WIN_C) begin
          state_d = AVAIL;
        end else begin
          state_d = PRIME;
        end
      end
      TAIL: begin
        if (cnt_m_s == '0) begin
          state_d = DONE;
        end else begin
          state_d = TAIL;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = PRIME;
    endcase
  end

  // State registers with synchronous reset taking priority over handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      state_q <= PRIME;
      err_q   <= 1'b0;
      bc_q    <= 32'd0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      err_q   <= err_d;
      bc_q    <= bc_d;
    end
  end

  assign bus.win           = sr_q[SR_W-1 -: WIN_W];
  assign bus.win_valid     = win_valid_s;
  assign bus.in_ready      = in_ready_s;
  assign bus.flush_ready   = win_valid_s;
  assign bus.align_ready   = align_ready_s;
  assign bus.done          = (state_q == DONE);
  assign bus.err           = err_q;
  assign bus.bits_consumed = bc_q;

endmodule
